// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared constants and phase encoding for the TL VC arbiter
package tl_pkg;

  localparam int DATA_W = 12;
  localparam int NUM_VC = 4;
  localparam int UMB_W  = 3;
  localparam int IDX_W  = 2;

  localparam logic [UMB_W-1:0] AF_RST = 3'd6;
  localparam logic [UMB_W-1:0] AE_RST = 3'd0;

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } tl_state_t;

endpackage

// File: rtl/tl_rr_arbiter.sv
// rtl/tl_rr_arbiter.sv - combinational VC grant: round-robin after ptr, or fixed
// priority (VC0 highest) when TL_VC_ARB_PRIORITY_EN is defined
module tl_rr_arbiter
  import tl_pkg::*;
(
  input  logic [NUM_VC-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_VC-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx
);

`ifdef TL_VC_ARB_PRIORITY_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    logic [IDX_W-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
`ifdef TL_VC_ARB_PRIORITY_EN
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      idx = IDX_W'(i);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
`else
    // Scan from farthest to nearest so the candidate right after ptr wins last.
    for (int k = NUM_VC; k >= 1; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
`endif
  end

endmodule

// File: rtl/tl_vc_arbiter.sv
// rtl/tl_vc_arbiter.sv - phase FSM, threshold distribution and VC-to-output drain
// pipeline; TL_VC_ARB_PRIORITY_EN selects fixed-priority arbitration
module tl_vc_arbiter
  import tl_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init,
  input  logic [UMB_W-1:0]         umbral_AF_in,
  input  logic [UMB_W-1:0]         umbral_AE_in,
  input  logic [NUM_VC*DATA_W-1:0] vc_data_in,
  input  logic [NUM_VC-1:0]        vc_empty,
  input  logic                     out_almost_full,
  output logic [3:0]               state,
  output logic [UMB_W-1:0]         umbral_AF_out,
  output logic [UMB_W-1:0]         umbral_AE_out,
  output logic [NUM_VC-1:0]        vc_pop,
  output logic                     out_push,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDX_W-1:0]         grant_vc
);

  tl_state_t          st;
  logic [NUM_VC-1:0]  req;
  logic [NUM_VC-1:0]  gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               pipe_vld;
  logic [IDX_W-1:0]   pipe_idx;
  logic [DATA_W-1:0]  sel_data;
  logic               busy;

  assign state = st;

  // A VC popped last cycle is masked: its registered empty flag is one cycle stale.
  assign req  = (st == ST_ACTIVE && !init && !out_almost_full) ? (~vc_empty & ~vc_pop) : '0;
  assign busy = (|vc_pop) | pipe_vld;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (pipe_idx == IDX_W'(i)) sel_data = vc_data_in[i*DATA_W +: DATA_W];
    end
  end

  tl_rr_arbiter u_arb (
    .req     (req),
    .ptr     (grant_vc),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st            <= ST_RESET;
      umbral_AF_out <= AF_RST;
      umbral_AE_out <= AE_RST;
      vc_pop        <= '0;
      grant_vc      <= '0;
      pipe_vld      <= 1'b0;
      pipe_idx      <= '0;
      out_push      <= 1'b0;
      out_data      <= '0;
    end else begin
      vc_pop <= gnt;
      if (|gnt) grant_vc <= gnt_idx;

      // Popped word appears on the VC FIFO output one cycle after the pop.
      pipe_vld <= |vc_pop;
      pipe_idx <= grant_vc;
      out_push <= pipe_vld;
      if (pipe_vld) out_data <= sel_data;

      case (st)
        ST_RESET: st <= ST_INIT;
        ST_INIT: begin
          umbral_AF_out <= umbral_AF_in;
          umbral_AE_out <= umbral_AE_in;
          if (!init) st <= ST_IDLE;
        end
        ST_IDLE: begin
          if (init) st <= ST_INIT;
          else if (!(&vc_empty) && !out_almost_full) st <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (init) st <= ST_INIT;
          else if ((&vc_empty) && !busy) st <= ST_IDLE;
        end
        default: st <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_vc_arbiter.sv
// tb/tb_tl_vc_arbiter.sv - directed self-checking bench for tl_vc_arbiter
`timescale 1ns/1ps
module tb_tl_vc_arbiter;
  import tl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset, init, out_almost_full;
  logic [UMB_W-1:0]         af_in, ae_in, af_out, ae_out;
  logic [NUM_VC*DATA_W-1:0] vc_data_in;
  logic [NUM_VC-1:0]        vc_empty, vc_pop;
  logic [3:0]               state;
  logic                     out_push;
  logic [DATA_W-1:0]        out_data;
  logic [1:0]               grant_vc;

  tl_vc_arbiter dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_AF_in(af_in), .umbral_AE_in(ae_in),
    .vc_data_in(vc_data_in), .vc_empty(vc_empty), .out_almost_full(out_almost_full),
    .state(state), .umbral_AF_out(af_out), .umbral_AE_out(ae_out),
    .vc_pop(vc_pop), .out_push(out_push), .out_data(out_data), .grant_vc(grant_vc)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // VC FIFO models with registered data_out and registered empty flag
  typedef logic [DATA_W-1:0] word_q_t [$];
  word_q_t           fifo_q [NUM_VC];
  logic [DATA_W-1:0] fifo_do [NUM_VC];
  int                underflows = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_VC; i++) begin
        fifo_q[i].delete();
        fifo_do[i]  <= '0;
        vc_empty[i] <= 1'b1;
      end
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        if (vc_pop[i]) begin
          if (fifo_q[i].size() == 0) underflows++;
          else fifo_do[i] <= fifo_q[i].pop_front();
        end
        vc_empty[i] <= (fifo_q[i].size() == 0);
      end
    end
  end

  always_comb begin
    vc_data_in = '0;
    for (int i = 0; i < NUM_VC; i++) vc_data_in[i*DATA_W +: DATA_W] = fifo_do[i];
  end

  // Monitor: log pops and pushes with the cycle they are visible in
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int                pop_cyc[$], pop_vc[$], push_cyc[$];
  logic [DATA_W-1:0] push_dat[$];
  int                multi_pops = 0;
  int                idle_c = 0;
  int                exp_vc[$];
  logic [DATA_W-1:0] exp_dat[$];

  function automatic int onehot_idx(input logic [NUM_VC-1:0] v);
    onehot_idx = -1;
    for (int i = NUM_VC - 1; i >= 0; i--) if (v[i]) onehot_idx = i;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (vc_pop != '0) begin
        if ($countones(vc_pop) != 1) multi_pops++;
        pop_cyc.push_back(cyc);
        pop_vc.push_back(onehot_idx(vc_pop));
      end
      if (out_push) begin
        push_cyc.push_back(cyc);
        push_dat.push_back(out_data);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    pop_cyc.delete(); pop_vc.delete(); push_cyc.delete(); push_dat.delete();
    exp_vc.delete(); exp_dat.delete();
  endtask

  task automatic load(input int vc, input logic [DATA_W-1:0] base, input int n);
    for (int k = 0; k < n; k++) fifo_q[vc].push_back(base + DATA_W'(k));
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
    for (int k = 0; k < budget && state !== s; k++) step();
    check(tag, 32'(state), 32'(s));
    idle_c = cyc;
  endtask

  task automatic wait_pops(input int n, input int budget, input string tag);
    for (int k = 0; k < budget && pop_vc.size() < n; k++) step();
    check(tag, pop_vc.size(), n);
  endtask

  // Compare logged pops/pushes against exp_vc/exp_dat; spacing 0 skips the gap check
  task automatic check_stream(input string tag, input int spacing);
    check({tag, "_npop"}, pop_vc.size(), exp_vc.size());
    check({tag, "_npush"}, push_dat.size(), exp_dat.size());
    for (int i = 0; i < exp_vc.size(); i++) begin
      if (i < pop_vc.size()) begin
        check($sformatf("%s_vc%0d", tag, i), pop_vc[i], exp_vc[i]);
        if (spacing > 0 && i > 0)
          check($sformatf("%s_gap%0d", tag, i), pop_cyc[i] - pop_cyc[i-1], spacing);
      end
    end
    for (int i = 0; i < exp_dat.size(); i++) begin
      if (i < push_dat.size()) begin
        check($sformatf("%s_dat%0d", tag, i), 32'(push_dat[i]), 32'(exp_dat[i]));
        if (i < pop_cyc.size())
          check($sformatf("%s_lat%0d", tag, i), push_cyc[i] - pop_cyc[i], 2);
      end
    end
    if (push_cyc.size() > 0)
      check({tag, "_idle_after_push"}, 32'(push_cyc[push_cyc.size()-1] < idle_c), 1);
    check({tag, "_underflow"}, underflows, 0);
    check({tag, "_onehot"}, multi_pops, 0);
  endtask

`ifdef TL_VC_ARB_PRIORITY_EN
  int all_seq[8] = '{0, 1, 0, 1, 2, 3, 2, 3};
`else
  int all_seq[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
`endif

  initial begin
    int af_c, drop_c, n_pop, n_push;
    int cnt[NUM_VC];

    init = 1'b0; out_almost_full = 1'b0; af_in = 3'd5; ae_in = 3'd1;
    reset = 1'b1;
    #1 reset = 1'b0;
    step(); step();
    check("rst_state", 32'(state), 32'h1);
    check("rst_pop", 32'(vc_pop), 0);
    check("rst_push", 32'(out_push), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_af", 32'(af_out), 6);
    check("rst_ae", 32'(ae_out), 0);
    check("rst_grant", 32'(grant_vc), 0);

    // Init phase: init high across three edges
    reset = 1'b1; init = 1'b1;
    check("seq0", 32'(state), 32'h1);
    step(); check("seq1", 32'(state), 32'h2);
    step(); check("seq2", 32'(state), 32'h2);
    step(); check("seq3", 32'(state), 32'h2);
    init = 1'b0;
    step(); check("seq4", 32'(state), 32'h4);
    check("init_af", 32'(af_out), 5);
    check("init_ae", 32'(ae_out), 1);

    // Single VC3 drains every other cycle
    clear_logs();
    load(3, 12'h3A0, 4);
    for (int k = 0; k < 4; k++) begin exp_vc.push_back(3); exp_dat.push_back(12'h3A0 + 12'(k)); end
    wait_state(4'h8, 10, "vc3_active");
    wait_state(4'h4, 40, "vc3_idle");
    check_stream("vc3", 2);
    check("vc3_grant", 32'(grant_vc), 3);

    // VC0 and VC2 interleave at one word per cycle (pointer left at VC3)
    clear_logs();
    load(0, 12'hA00, 3);
    load(2, 12'hC00, 3);
    for (int k = 0; k < 3; k++) begin
      exp_vc.push_back(0); exp_dat.push_back(12'hA00 + 12'(k));
      exp_vc.push_back(2); exp_dat.push_back(12'hC00 + 12'(k));
    end
    wait_state(4'h8, 10, "ac_active");
    wait_state(4'h4, 40, "ac_idle");
    check_stream("ac", 1);

    // Back-pressure in the middle of a VC0/VC1 stream
    clear_logs();
    load(0, 12'h0E0, 4);
    load(1, 12'h1F0, 4);
    for (int k = 0; k < 4; k++) begin
      exp_vc.push_back(0); exp_dat.push_back(12'h0E0 + 12'(k));
      exp_vc.push_back(1); exp_dat.push_back(12'h1F0 + 12'(k));
    end
    wait_pops(2, 20, "af_start");
    out_almost_full = 1'b1;
    af_c = cyc;
    repeat (5) step();
    out_almost_full = 1'b0;
    drop_c = cyc;
    wait_state(4'h4, 60, "af_idle");
    n_pop = 0; n_push = 0;
    foreach (pop_cyc[i]) if (pop_cyc[i] > af_c && pop_cyc[i] <= drop_c) n_pop++;
    foreach (push_cyc[i]) if (push_cyc[i] > af_c && push_cyc[i] <= drop_c + 1) n_push++;
    check("af_no_pop", n_pop, 0);
    check("af_inflight", n_push, 2);
    if (pop_cyc.size() > 2) check("af_resume", pop_cyc[2], drop_c + 1);
    check_stream("af", 0);

    // Async reset while a push is on the output
    clear_logs();
    load(1, 12'hB10, 4);
    for (int k = 0; k < 40 && !out_push; k++) step();
    check("mid_push_seen", 32'(out_push), 1);
    #2 reset = 1'b0;
    #1;
    check("mid_state", 32'(state), 32'h1);
    check("mid_pop", 32'(vc_pop), 0);
    check("mid_push", 32'(out_push), 0);
    check("mid_grant", 32'(grant_vc), 0);
    check("mid_af", 32'(af_out), 6);
    step();
    reset = 1'b1;
    clear_logs();
    check("rel_seq0", 32'(state), 32'h1);
    step(); check("rel_seq1", 32'(state), 32'h2);
    step(); check("rel_seq2", 32'(state), 32'h4);
    check("rel_af", 32'(af_out), 5);
    repeat (4) step();
    check("rel_no_push", push_dat.size(), 0);

    // All four VCs loaded with two words each
    clear_logs();
    for (int v = 0; v < NUM_VC; v++) begin
      load(v, 12'h800 + 12'(v * 16), 2);
      cnt[v] = 0;
    end
    foreach (all_seq[i]) begin
      exp_vc.push_back(all_seq[i]);
      exp_dat.push_back(12'h800 + 12'(all_seq[i] * 16 + cnt[all_seq[i]]));
      cnt[all_seq[i]]++;
    end
    wait_state(4'h8, 10, "all_active");
    wait_state(4'h4, 40, "all_idle");
    check_stream("all", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
